// File: rtl/tile_map_pkg.sv
// Shared tile-map constants, opcodes and word helpers.
// Used by the map controller, the grid controller and the pixel generator.
package tile_map_pkg;

  localparam int ADDR_W         = 8;
  localparam int N_WORDS        = 1 << ADDR_W;
  localparam int TILES_PER_WORD = 8;
  localparam int TILE_BITS      = 4;
  localparam int WORD_W         = TILES_PER_WORD * TILE_BITS;
  localparam int SLOT_W         = $clog2(TILES_PER_WORD);

  localparam logic [1:0] OP_WR_TILE = 2'd0;
  localparam logic [1:0] OP_WR_WORD = 2'd1;
  localparam logic [1:0] OP_FILL    = 2'd2;
  localparam logic [1:0] OP_NOP     = 2'd3;

  function automatic logic [WORD_W-1:0] set_slot(
    input logic [WORD_W-1:0]    w,
    input logic [SLOT_W-1:0]    s,
    input logic [TILE_BITS-1:0] c
  );
    logic [WORD_W-1:0] r;
    r = w;
    for (int i = 0; i < TILES_PER_WORD; i++)
      if (s == SLOT_W'(i))
        r[i*TILE_BITS +: TILE_BITS] = c;
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] fill_word(
    input logic [TILE_BITS-1:0] c
  );
    return {TILES_PER_WORD{c}};
  endfunction

endpackage

// File: rtl/tile_map_ram.sv
// Simple dual-port map RAM: one write port, one registered read port.
// Reads return the pre-write contents on an address collision.
module tile_map_ram
  import tile_map_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [N_WORDS];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  // output register reset maps onto the BRAM output-latch reset
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_rdata <= '0;
    else
      r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tile_map_ctrl.sv
// Tile-map store: pixel read port plus command port for
// single-tile RMW, whole-word write and full-map fill.
module tile_map_ctrl
  import tile_map_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   current_tile,
  output logic [WORD_W-1:0]   sprite_addr,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W+2:0]   cmd_tile,
  input  logic [WORD_W-1:0]   cmd_data,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RMW_RD = 2'd1;
  localparam logic [1:0] S_RMW_WR = 2'd2;
  localparam logic [1:0] S_FILL   = 2'd3;

  logic [1:0]           r_state;
  logic [ADDR_W-1:0]    r_word;
  logic [SLOT_W-1:0]    r_slot;
  logic [TILE_BITS-1:0] r_code;
  logic [WORD_W-1:0]    r_hold;
  logic [ADDR_W-1:0]    r_fill_idx;
  logic [TILE_BITS-1:0] r_fill_code;
  logic                 r_done;

  logic                 w_idle;
  logic                 w_fire;
  logic [ADDR_W-1:0]    w_cmd_word;
  logic [SLOT_W-1:0]    w_cmd_slot;
  logic [TILE_BITS-1:0] w_cmd_code;
  logic                 w_we;
  logic [ADDR_W-1:0]    w_waddr;
  logic [WORD_W-1:0]    w_wdata;
  logic [ADDR_W-1:0]    w_rmw_addr;
  logic [WORD_W-1:0]    w_rmw_q;

  assign w_idle     = (r_state == S_IDLE);
  assign w_fire     = cmd_valid & w_idle;
  assign w_cmd_word = cmd_tile[ADDR_W+2:SLOT_W];
  assign w_cmd_slot = cmd_tile[SLOT_W-1:0];
  assign w_cmd_code = cmd_data[TILE_BITS-1:0];

  assign cmd_ready = w_idle;
  assign busy      = ~w_idle;
  assign done      = r_done;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    unique case (1'b1)
      (r_state == S_FILL): begin
        w_we    = 1'b1;
        w_waddr = r_fill_idx;
        w_wdata = fill_word(r_fill_code);
      end
      (r_state == S_RMW_WR): begin
        w_we    = 1'b1;
        w_waddr = r_word;
        w_wdata = set_slot(r_hold, r_slot, r_code);
      end
      (w_fire && cmd_op == OP_WR_WORD): begin
        w_we    = 1'b1;
        w_waddr = w_cmd_word;
        w_wdata = cmd_data;
      end
      default: ;
    endcase
  end

  // RMW copy is addressed by the incoming command so its word is ready in RMW_RD
  assign w_rmw_addr = w_idle ? w_cmd_word : r_word;

  tile_map_ram u_pix_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (current_tile),
    .o_rdata (sprite_addr)
  );

  tile_map_ram u_rmw_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_rmw_addr),
    .o_rdata (w_rmw_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_word      <= '0;
      r_slot      <= '0;
      r_code      <= '0;
      r_hold      <= '0;
      r_fill_idx  <= '0;
      r_fill_code <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            unique case (cmd_op)
              OP_WR_TILE: begin
                r_word  <= w_cmd_word;
                r_slot  <= w_cmd_slot;
                r_code  <= w_cmd_code;
                r_state <= S_RMW_RD;
              end
              OP_FILL: begin
                r_fill_code <= w_cmd_code;
                r_fill_idx  <= '0;
                r_state     <= S_FILL;
              end
              OP_WR_WORD: r_done <= 1'b1;
              OP_NOP:     r_done <= 1'b1;
            endcase
          end
        end
        S_RMW_RD: begin
          r_hold  <= w_rmw_q;
          r_state <= S_RMW_WR;
        end
        S_RMW_WR: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        S_FILL: begin
          if (r_fill_idx == ADDR_W'(N_WORDS-1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_fill_idx <= r_fill_idx + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Directed bench for tile_map_ctrl: reset clear, RMW, word write,
// fill, reset during fill and back-to-back commands.
module tb_tile_map_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  current_tile = '0;
  logic [31:0] sprite_addr;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd3;
  logic [10:0] cmd_tile = '0;
  logic [31:0] cmd_data = '0;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  tile_map_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .current_tile (current_tile),
    .sprite_addr  (sprite_addr),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_tile     (cmd_tile),
    .cmd_data     (cmd_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input logic [7:0] a, output logic [31:0] d);
    current_tile = a;
    tick();
    d = sprite_addr;
  endtask

  task automatic count_bad(input logic [31:0] exp, output int bad);
    logic [31:0] d;
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      read_word(8'(a), d);
      if (d !== exp) bad++;
    end
  endtask

  // waits for ready (bounded), accepts on the next edge, drops valid
  task automatic issue(input logic [1:0] op, input logic [10:0] t,
                       input logic [31:0] d, output int waited);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_tile  = t;
    cmd_data  = d;
    waited    = 0;
    while (!cmd_ready && waited < 1000) begin
      tick();
      waited++;
    end
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
  endtask

  // counts busy samples until idle, bounded
  task automatic wait_idle(output int n, output int dn, output int rdy_bad);
    n = 0; dn = 0; rdy_bad = 0;
    while (busy && n < 400) begin
      if (cmd_ready) rdy_bad++;
      n++;
      tick();
      if (done) dn++;
    end
  endtask

  task automatic test_reset();
    int n, dn, rb, bad;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (sprite_addr !== 32'h0 || done !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: addr=%h done=%b busy=%b rdy=%b want 0/0/1/0",
               sprite_addr, done, busy, cmd_ready);
    end
    wait_idle(n, dn, rb);
    checks++;
    if (n !== 256) begin
      errors++; $display("FAIL reset_busy_len: got %0d want 256", n);
    end
    checks++;
    if (dn !== 1 || done !== 1'b1 || cmd_ready !== 1'b1 || rb !== 0) begin
      errors++;
      $display("FAIL reset_done: pulses=%0d done=%b rdy=%b rdy_while_busy=%0d want 1/1/1/0",
               dn, done, cmd_ready, rb);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done_width: done=%b want 0", done);
    end
    count_bad(32'h0, bad);
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_clear: %0d words nonzero want 0", bad);
    end
  endtask

  task automatic test_wr_tile();
    int w;
    logic [31:0] d;
    logic [2:0] dseq;
    issue(2'd1, {8'd5, 3'd0}, 32'h12345678, w);
    tick();
    issue(2'd0, {8'd5, 3'd3}, 32'h0000000A, w);
    dseq[0] = done;
    tick(); dseq[1] = done;
    tick(); dseq[2] = done;
    checks++;
    if (dseq !== 3'b100) begin
      errors++; $display("FAIL wr_tile_done_timing: seq=%b want 100", dseq);
    end
    read_word(8'd5, d);
    checks++;
    if (d !== 32'h1234A678) begin
      errors++; $display("FAIL wr_tile_slot3: got %h want 1234a678", d);
    end
    issue(2'd0, {8'd6, 3'd7}, 32'hFFFFFFF3, w);
    tick(); tick();
    read_word(8'd6, d);
    checks++;
    if (d !== 32'h30000000) begin
      errors++; $display("FAIL wr_tile_slot7_trunc: got %h want 30000000", d);
    end
    issue(2'd0, {8'd255, 3'd0}, 32'h00000005, w);
    tick(); tick();
    read_word(8'd255, d);
    checks++;
    if (d !== 32'h00000005) begin
      errors++; $display("FAIL wr_tile_word255_slot0: got %h want 00000005", d);
    end
  endtask

  task automatic test_wr_word();
    int w;
    logic [31:0] d;
    issue(2'd1, {8'd9, 3'd0}, 32'h0BADF00D, w);
    tick();
    current_tile = 8'd9;
    issue(2'd1, {8'd9, 3'd5}, 32'hDEADBEEF, w);
    checks++;
    if (sprite_addr !== 32'h0BADF00D || done !== 1'b1) begin
      errors++;
      $display("FAIL wr_word_old: got %h done=%b want 0badf00d done=1", sprite_addr, done);
    end
    tick();
    checks++;
    if (sprite_addr !== 32'hDEADBEEF || done !== 1'b0) begin
      errors++;
      $display("FAIL wr_word_new: got %h done=%b want deadbeef done=0", sprite_addr, done);
    end
    issue(2'd3, {8'd9, 3'd0}, 32'h11111111, w);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL nop_done: done=%b busy=%b want 1/0", done, busy);
    end
    read_word(8'd9, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL nop_no_effect: got %h want deadbeef", d);
    end
  endtask

  task automatic test_fill();
    int w, n, dn, rb;
    logic [31:0] d;
    logic [2:0] dseq;
    issue(2'd2, '0, 32'hFFFFFFF7, w);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_tile  = {8'd0, 3'd0};
    cmd_data  = 32'h00000002;
    wait_idle(n, dn, rb);
    checks++;
    if (n !== 256 || dn !== 1 || done !== 1'b1) begin
      errors++; $display("FAIL fill_len: busy=%0d pulses=%0d done=%b want 256/1/1", n, dn, done);
    end
    checks++;
    if (rb !== 0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL fill_ready: early_ready=%0d rdy=%b want 0/1", rb, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
    dseq[0] = done;
    tick(); dseq[1] = done;
    tick(); dseq[2] = done;
    checks++;
    if (dseq !== 3'b100) begin
      errors++; $display("FAIL fill_pending_cmd: done seq=%b want 100", dseq);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL fill_taken_once: busy=%b done=%b want 0/0", busy, done);
    end
    read_word(8'd0, d);
    checks++;
    if (d !== 32'h77777772) begin
      errors++; $display("FAIL fill_word0: got %h want 77777772", d);
    end
    read_word(8'd255, d);
    checks++;
    if (d !== 32'h77777777) begin
      errors++; $display("FAIL fill_word255: got %h want 77777777", d);
    end
    read_word(8'd128, d);
    checks++;
    if (d !== 32'h77777777) begin
      errors++; $display("FAIL fill_word128: got %h want 77777777", d);
    end
  endtask

  task automatic test_reset_mid_fill();
    int w, n, dn, rb, bad;
    current_tile = 8'd50;
    issue(2'd2, '0, 32'h00000009, w);
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if (sprite_addr !== 32'h99999999 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midfill_progress: got %h busy=%b want 99999999/1", sprite_addr, busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0 || sprite_addr !== 32'h0) begin
      errors++;
      $display("FAIL midfill_reset_state: busy=%b rdy=%b done=%b addr=%h want 1/0/0/0",
               busy, cmd_ready, done, sprite_addr);
    end
    wait_idle(n, dn, rb);
    checks++;
    if (n !== 256 || dn !== 1) begin
      errors++; $display("FAIL midfill_clear_len: busy=%0d pulses=%0d want 256/1", n, dn);
    end
    tick();
    count_bad(32'h0, bad);
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL midfill_clear: %0d words nonzero want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int dn;
    logic [31:0] d;
    dn = 0;
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_tile  = {8'd20, 3'd0};
    cmd_data  = 32'hCAFEF00D;
    tick();
    if (done) dn++;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_first: rdy=%b done=%b want 1/1", cmd_ready, done);
    end
    cmd_op   = 2'd0;
    cmd_tile = {8'd20, 3'd1};
    cmd_data = 32'h0000000B;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
    if (done) dn++;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept: busy=%b want 1", busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dn++;
    end
    checks++;
    if (dn !== 2) begin
      errors++; $display("FAIL b2b_done_count: got %0d want 2", dn);
    end
    read_word(8'd20, d);
    checks++;
    if (d !== 32'hCAFEF0BD) begin
      errors++; $display("FAIL b2b_word20: got %h want cafef0bd", d);
    end
  endtask

  initial begin
    test_reset();
    test_wr_tile();
    test_wr_word();
    test_fill();
    test_reset_mid_fill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
